prng_req_arbiter: RTL and testbench

PRNG_REQ_ARBITER -- requirements
Module: prng_req_arbiter

---
 rtl/prng_pkg.sv | 17 +
 rtl/prng_req_arbiter_if.sv | 35 +++
 rtl/rr_pick.sv | 42 ++++
 rtl/prng_req_arbiter.sv | 172 +++++++++++++++++
 tb/tb_prng_req_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/prng_pkg.sv
// prng_pkg: shared constants and types for the PRNG request arbiter.
//   LCG_A, LCG_C : multiplier and increment of the LCG step (5*s + 1).
//   CNT_W        : width of the optional accepted-word counter.
//   state_t      : arbiter FSM states.
package prng_pkg;

    localparam int unsigned LCG_A = 5;
    localparam int unsigned LCG_C = 1;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEED = 2'd1,
        BUSY = 2'd2
    } state_t;

endpackage

// File: rtl/prng_req_arbiter_if.sv
// prng_req_arbiter_if: requester / consumer / seed-load bundle.
//   load_seed, seed_data : seed load request and value
//   req                  : per-requester level requests
//   gnt                  : one-hot grant of the word being delivered
//   rnd_valid/rnd_ready  : delivery handshake
//   rnd_data, rnd_id     : delivered word and winning requester index
//   seed_busy            : seed load pending or executing
// master = client side (drives requests), slave = arbiter side.
interface prng_req_arbiter_if #(
    parameter int unsigned N       = 8,
    parameter int unsigned NUM_REQ = 4
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic                 load_seed;
    logic [N-1:0]         seed_data;
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   gnt;
    logic                 rnd_valid;
    logic [N-1:0]         rnd_data;
    logic [ID_W-1:0]      rnd_id;
    logic                 rnd_ready;
    logic                 seed_busy;

    modport master (
        output load_seed, seed_data, req, rnd_ready,
        input  gnt, rnd_valid, rnd_data, rnd_id, seed_busy
    );

    modport slave (
        input  load_seed, seed_data, req, rnd_ready,
        output gnt, rnd_valid, rnd_data, rnd_id, seed_busy
    );

endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin winner selection.
//   req      : request vector
//   ptr      : index of the last winner; search starts at ptr+1 with wrap
//   winner_c : index of the selected requester (0 when none)
//   found_c  : at least one request present
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    winner_c,
    output logic               found_c
);

    logic [NUM_REQ-1:0] rot;
    logic [NUM_REQ-1:0] scan;
    int unsigned        offset;
    int unsigned        sum;

    // Rotate so bit 0 is requester ptr+1, then find the lowest set bit.
    always_comb begin
        rot    = NUM_REQ'({req, req} >> (32'(ptr) + 32'd1));
        scan   = rot;
        offset = 0;
        found_c = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!found_c && scan[0]) begin
                found_c = 1'b1;
                offset  = k;
            end
            scan = scan >> 1;
        end
        // ptr+1+offset is below 2*NUM_REQ, so a single wrap suffices.
        sum = 32'(ptr) + 32'd1 + offset;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        winner_c = found_c ? ID_W'(sum) : '0;
    end

endmodule

// File: rtl/prng_req_arbiter.sv
// prng_req_arbiter: round-robin arbiter that hands one word of an 8-bit-style
// LCG (next = 5*s + 1 mod 2^N) to each granted requester.
//   clk       : clock, all logic on posedge
//   reset     : asynchronous active-low reset
//   bus       : prng_req_arbiter_if.slave (requests, seed load, delivery)
//   grant_cnt : saturating count of accepted words, present only when
//               PRNG_ARB_GRANT_CNT_EN is defined
// The LCG advances only when a presented word is accepted. A seed load is
// latched at any time and applied from IDLE, ahead of any request.
module prng_req_arbiter
    import prng_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned SEED_INIT = 1
) (
    input  logic                clk,
    input  logic                reset,
    prng_req_arbiter_if.slave   bus
`ifdef PRNG_ARB_GRANT_CNT_EN
    ,
    output logic [CNT_W-1:0]    grant_cnt
`endif
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    state_t               state_q, state_n;
    logic [N-1:0]         lcg_q, lcg_n;
    logic [ID_W-1:0]      ptr_q, ptr_n;
    logic                 pending_q, pending_n;
    logic [N-1:0]         seed_q, seed_n;
    logic [NUM_REQ-1:0]   gnt_q, gnt_n;
    logic                 valid_q, valid_n;
    logic [N-1:0]         data_q, data_n;
    logic [ID_W-1:0]      id_q, id_n;
    logic                 busy_q, busy_n;

    logic [ID_W-1:0]      pick_id_c;
    logic                 pick_found_c;
    logic                 accept_c;
    logic [N-1:0]         lcg_step_c;

`ifdef PRNG_ARB_GRANT_CNT_EN
    logic [CNT_W-1:0]     cnt_q, cnt_n;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req      (bus.req),
        .ptr      (ptr_q),
        .winner_c (pick_id_c),
        .found_c  (pick_found_c)
    );

    // LCG step with the product truncated to N bits.
    assign lcg_step_c = N'(N'(LCG_A) * lcg_q + N'(LCG_C));
    assign accept_c   = valid_q && bus.rnd_ready;

    // Next-state and next-output logic.
    always_comb begin
        state_n   = state_q;
        lcg_n     = lcg_q;
        ptr_n     = ptr_q;
        pending_n = pending_q;
        seed_n    = seed_q;
        gnt_n     = gnt_q;
        valid_n   = valid_q;
        data_n    = data_q;
        id_n      = id_q;
`ifdef PRNG_ARB_GRANT_CNT_EN
        cnt_n     = cnt_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.load_seed || pending_q) begin
                    state_n   = SEED;
                    pending_n = 1'b1;
                    if (bus.load_seed) begin
                        seed_n = bus.seed_data;
                    end
                end else if (pick_found_c) begin
                    state_n = BUSY;
                    gnt_n   = NUM_REQ'(1) << pick_id_c;
                    id_n    = pick_id_c;
                    data_n  = lcg_q;
                    valid_n = 1'b1;
                end
            end
            SEED: begin
                lcg_n     = seed_q;
                pending_n = 1'b0;
                state_n   = IDLE;
                // A load arriving here is kept for the next pass through SEED.
                if (bus.load_seed) begin
                    seed_n    = bus.seed_data;
                    pending_n = 1'b1;
                end
            end
            BUSY: begin
                if (bus.load_seed) begin
                    seed_n    = bus.seed_data;
                    pending_n = 1'b1;
                end
                if (accept_c) begin
                    gnt_n   = '0;
                    valid_n = 1'b0;
                    lcg_n   = lcg_step_c;
                    ptr_n   = id_q;
                    state_n = IDLE;
`ifdef PRNG_ARB_GRANT_CNT_EN
                    if (cnt_q != '1) begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
`endif
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = pending_n || (state_n == SEED);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            lcg_q     <= N'(SEED_INIT);
            ptr_q     <= ID_W'(NUM_REQ - 1);
            pending_q <= 1'b0;
            seed_q    <= '0;
            gnt_q     <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            id_q      <= '0;
            busy_q    <= 1'b0;
`ifdef PRNG_ARB_GRANT_CNT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_n;
            lcg_q     <= lcg_n;
            ptr_q     <= ptr_n;
            pending_q <= pending_n;
            seed_q    <= seed_n;
            gnt_q     <= gnt_n;
            valid_q   <= valid_n;
            data_q    <= data_n;
            id_q      <= id_n;
            busy_q    <= busy_n;
`ifdef PRNG_ARB_GRANT_CNT_EN
            cnt_q     <= cnt_n;
`endif
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rnd_valid = valid_q;
    assign bus.rnd_data  = data_q;
    assign bus.rnd_id    = id_q;
    assign bus.seed_busy = busy_q;

`ifdef PRNG_ARB_GRANT_CNT_EN
    assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_prng_req_arbiter.sv
// tb_prng_req_arbiter: self-checking bench for prng_req_arbiter
// (N=8, NUM_REQ=4, SEED_INIT=1). Expected words are queued when a request
// is driven and compared when the arbiter hands a word over.
// Define PRNG_ARB_GRANT_CNT_EN to also check grant_cnt.
module tb_prng_req_arbiter;

    localparam int unsigned N       = 8;
    localparam int unsigned NUM_REQ = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    prng_req_arbiter_if #(.N(N), .NUM_REQ(NUM_REQ)) bus ();

`ifdef PRNG_ARB_GRANT_CNT_EN
    logic [15:0] grant_cnt;
`endif

    prng_req_arbiter #(
        .N         (N),
        .NUM_REQ   (NUM_REQ),
        .SEED_INIT (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus)
`ifdef PRNG_ARB_GRANT_CNT_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] id;
    } exp_t;

    typedef struct {
        logic       load;
        logic [7:0] seed;
        logic [3:0] req;
        logic [7:0] data;
        logic [1:0] id;
    } vec_t;

    int   checks    = 0;
    int   failures  = 0;
    int   accepted  = 0;
    int   acc_base  = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, want);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic [1:0] i);
        exp_t e;
        e.data = d;
        e.id   = i;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until the accepted-word count reaches target.
    task automatic wait_accept(input int target);
        for (int c = 0; c < 50 && accepted < target; c++) begin
            tick();
        end
        check("accept_timeout", 32'(accepted >= target), 32'd1);
    endtask

    task automatic check_cnt(input string name);
`ifdef PRNG_ARB_GRANT_CNT_EN
        check(name, 32'(grant_cnt), 32'(accepted - acc_base));
`else
        if (name.len() == 0) begin
            $display("empty counter check name");
        end
`endif
    endtask

    // Scoreboard: every handed-over word is compared to the oldest expectation.
    always @(negedge clk) begin
        if (reset && bus.rnd_valid && bus.rnd_ready) begin
            accepted++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word actual=0x%0h required=none", bus.rnd_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("rnd_data", 32'(bus.rnd_data), 32'(mon_e.data));
                check("rnd_id", 32'(bus.rnd_id), 32'(mon_e.id));
                check("gnt_onehot", 32'(bus.gnt), 32'd1 << mon_e.id);
            end
        end
    end

    initial begin
        vecs[0]  = '{1'b0, 8'h00, 4'b1111, 8'h01, 2'd0};
        vecs[1]  = '{1'b0, 8'h00, 4'b1111, 8'h06, 2'd1};
        vecs[2]  = '{1'b0, 8'h00, 4'b1111, 8'h1F, 2'd2};
        vecs[3]  = '{1'b0, 8'h00, 4'b1111, 8'h9C, 2'd3};
        vecs[4]  = '{1'b0, 8'h00, 4'b1111, 8'h0D, 2'd0};
        vecs[5]  = '{1'b1, 8'h00, 4'b0001, 8'h00, 2'd0};
        vecs[6]  = '{1'b0, 8'h00, 4'b0001, 8'h01, 2'd0};
        vecs[7]  = '{1'b0, 8'h00, 4'b0001, 8'h06, 2'd0};
        vecs[8]  = '{1'b0, 8'h00, 4'b0001, 8'h1F, 2'd0};
        vecs[9]  = '{1'b1, 8'hFF, 4'b0001, 8'hFF, 2'd0};
        vecs[10] = '{1'b0, 8'h00, 4'b0001, 8'hFC, 2'd0};
        vecs[11] = '{1'b0, 8'h00, 4'b1010, 8'hED, 2'd1};
        vecs[12] = '{1'b0, 8'h00, 4'b1010, 8'hA2, 2'd3};
        vecs[13] = '{1'b0, 8'h00, 4'b0100, 8'h2B, 2'd2};

        reset         = 1'b0;
        bus.load_seed = 1'b0;
        bus.seed_data = '0;
        bus.req       = '0;
        bus.rnd_ready = 1'b0;

        #12;
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_valid", 32'(bus.rnd_valid), 32'd0);
        check("rst_data", 32'(bus.rnd_data), 32'd0);
        check("rst_id", 32'(bus.rnd_id), 32'd0);
        check("rst_seed_busy", 32'(bus.seed_busy), 32'd0);
        check_cnt("rst_grant_cnt");

        tick();
        reset         = 1'b1;
        bus.rnd_ready = 1'b1;

        // Table-driven words with the consumer always ready.
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].load) begin
                tick();
                bus.load_seed = 1'b1;
                bus.seed_data = vecs[i].seed;
                tick();
                bus.load_seed = 1'b0;
                check("seed_busy_set", 32'(bus.seed_busy), 32'd1);
                for (int c = 0; c < 20 && bus.seed_busy; c++) begin
                    tick();
                end
                check("seed_busy_clear", 32'(bus.seed_busy), 32'd0);
            end
            tick();
            push_exp(vecs[i].data, vecs[i].id);
            bus.req = vecs[i].req;
            begin
                int target;
                target = accepted + 1;
                tick();
                check("latency_valid", 32'(bus.rnd_valid), 32'd1);
                wait_accept(target);
            end
            bus.req = '0;
        end
        check_cnt("grant_cnt_table");

        // Stall with a seed load and a dropped request during BUSY.
        begin
            int target;
            tick();
            bus.rnd_ready = 1'b0;
            bus.req       = 4'b0001;
            push_exp(8'hD8, 2'd0);
            push_exp(8'h40, 2'd0);
            target = accepted + 2;
            tick();
            check("stall_valid", 32'(bus.rnd_valid), 32'd1);
            bus.req       = '0;
            bus.load_seed = 1'b1;
            bus.seed_data = 8'h40;
            tick();
            bus.load_seed = 1'b0;
            bus.seed_data = 8'h99;
            for (int k = 0; k < 5; k++) begin
                check("stall_valid_hold", 32'(bus.rnd_valid), 32'd1);
                check("stall_data_hold", 32'(bus.rnd_data), 32'hD8);
                check("stall_gnt_hold", 32'(bus.gnt), 32'h1);
                check("stall_seed_busy", 32'(bus.seed_busy), 32'd1);
                tick();
            end
            check_cnt("grant_cnt_stall");
            bus.rnd_ready = 1'b1;
            bus.req       = 4'b0001;
            wait_accept(target);
            bus.req = '0;
            check("post_seed_busy", 32'(bus.seed_busy), 32'd0);
        end

        // Reset in the middle of a transfer.
        begin
            int target;
            tick();
            bus.rnd_ready = 1'b0;
            bus.req       = 4'b0010;
            tick();
            check("pre_reset_valid", 32'(bus.rnd_valid), 32'd1);
            #3;
            reset = 1'b0;
            #1;
            check("mid_rst_gnt", 32'(bus.gnt), 32'd0);
            check("mid_rst_valid", 32'(bus.rnd_valid), 32'd0);
            check("mid_rst_data", 32'(bus.rnd_data), 32'd0);
            check("mid_rst_id", 32'(bus.rnd_id), 32'd0);
            check("mid_rst_seed_busy", 32'(bus.seed_busy), 32'd0);
            bus.req = '0;
            acc_base = accepted;
            check_cnt("mid_rst_grant_cnt");
            tick();
            reset         = 1'b1;
            bus.rnd_ready = 1'b1;
            bus.req       = 4'b0001;
            push_exp(8'h01, 2'd0);
            target = accepted + 1;
            wait_accept(target);
            bus.req = '0;
            check_cnt("grant_cnt_after_reset");
        end

        tick();
        tick();
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
